// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for pipeline stage registers: occupancy state and helpers.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_t st);
    case (st)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble
// and an optional 2-entry skid buffer that registers in_ready.
//
// state    | meaning
// PS_EMPTY | no valid entry, out_data = NOP_VALUE
// PS_ONE   | main register valid
// PS_TWO   | main and skid registers valid, upstream stalled
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      PS_EMPTY: begin
        if (in_fire) begin
          state_d = PS_ONE;
          main_d  = in_data;
        end
      end
      PS_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && !out_ready) begin
          state_d = PS_TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = PS_EMPTY;
          main_d  = NOP_VALUE;
        end
      end
      PS_TWO: begin
        if (out_fire) begin
          state_d = PS_ONE;
          main_d  = skid_q;
          skid_d  = NOP_VALUE;
        end
      end
      default: begin
        state_d = PS_EMPTY;
        main_d  = NOP_VALUE;
        skid_d  = NOP_VALUE;
      end
    endcase
    // Flush overrides every handshake; an accepted input this cycle is lost.
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end
    occ_d = state_occupancy(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      occ_q   <= occ_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_ready_q, in_ready_d;
      assign in_ready_d = (state_d != PS_TWO);
      always_ff @(posedge CLK) begin
        if (!nRST) in_ready_q <= 1'b1;
        else       in_ready_q <= in_ready_d;
      end
      // Held low while reset is asserted so nothing is accepted mid-reset.
      assign in_ready = in_ready_q & nRST;
    end else begin : g_flow
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg with and without skid buffer.
module tb_pipe_stage_reg;

  localparam logic [7:0] NOP = 8'hFF;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occ;
  logic       f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [7:0] f_in_data, f_out_data;
  logic [1:0] f_occ;

  pipe_stage_reg #(.WIDTH(8), .NOP_VALUE(8'hFF), .SKID(1'b1)) u_skid (
    .CLK(CLK), .nRST(nRST), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  pipe_stage_reg #(.WIDTH(8), .NOP_VALUE(8'hFF), .SKID(1'b0)) u_flow (
    .CLK(CLK), .nRST(nRST), .flush(f_flush),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
    .occupancy(f_occ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic s_inf, s_outf, f_inf, f_outf;

  initial begin
    nRST = 1'b0;
    s_flush = 0; s_in_valid = 0; s_in_data = 8'h00; s_out_ready = 0;
    f_flush = 0; f_in_valid = 0; f_in_data = 8'h00; f_out_ready = 0;
    #1;
    chk("reset_in_ready_low", {31'd0, s_in_ready}, 32'd0);
    step();
    chk("reset_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, s_out_data}, {24'd0, NOP});
    chk("reset_occ", {30'd0, s_occ}, 32'd0);
    chk("reset_flow_out_valid", {31'd0, f_out_valid}, 32'd0);
    nRST = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, s_in_ready}, 32'd1);

    // streaming
    s_out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      s_in_valid = 1; s_in_data = 8'(i);
      #1;
      chk("stream_in_ready", {31'd0, s_in_ready}, 32'd1);
      step();
      chk("stream_valid", {31'd0, s_out_valid}, 32'd1);
      chk("stream_data", {24'd0, s_out_data}, 32'(i));
    end
    s_in_valid = 0;
    step();
    chk("stream_drain_valid", {31'd0, s_out_valid}, 32'd0);
    chk("stream_drain_data", {24'd0, s_out_data}, {24'd0, NOP});

    // stall / skid
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'hA1;
    step();
    chk("skid_one_occ", {30'd0, s_occ}, 32'd1);
    chk("skid_one_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_in_data = 8'hA2;
    step();
    chk("skid_two_occ", {30'd0, s_occ}, 32'd2);
    chk("skid_two_in_ready", {31'd0, s_in_ready}, 32'd0);
    chk("skid_two_data", {24'd0, s_out_data}, 32'hA1);
    s_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("skid_hold_data", {24'd0, s_out_data}, 32'hA1);
    end
    s_out_ready = 1;
    step();
    chk("skid_rel1_data", {24'd0, s_out_data}, 32'hA2);
    chk("skid_rel1_occ", {30'd0, s_occ}, 32'd1);
    chk("skid_rel1_in_ready", {31'd0, s_in_ready}, 32'd1);
    step();
    chk("skid_rel2_valid", {31'd0, s_out_valid}, 32'd0);
    chk("skid_rel2_data", {24'd0, s_out_data}, {24'd0, NOP});

    // flush in TWO with a pending input
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'hB1; step();
    s_in_data = 8'hB2; step();
    chk("flush_pre_occ", {30'd0, s_occ}, 32'd2);
    s_flush = 1; s_in_data = 8'hB3;
    step();
    chk("flush_two_valid", {31'd0, s_out_valid}, 32'd0);
    chk("flush_two_data", {24'd0, s_out_data}, {24'd0, NOP});
    chk("flush_two_occ", {30'd0, s_occ}, 32'd0);
    chk("flush_two_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_flush = 0; s_in_valid = 0; s_out_ready = 1;
    step();
    chk("flush_no_b3", {31'd0, s_out_valid}, 32'd0);

    // flush in ONE discards an accepted input
    s_out_ready = 0; s_in_valid = 1; s_in_data = 8'hB4; step();
    s_flush = 1; s_in_data = 8'hB5; step();
    chk("flush_one_valid", {31'd0, s_out_valid}, 32'd0);
    chk("flush_one_occ", {30'd0, s_occ}, 32'd0);
    s_flush = 0; s_in_valid = 0;

    // single-entry variant
    f_out_ready = 0; f_in_valid = 1; f_in_data = 8'hC1;
    #1;
    chk("flow_empty_in_ready", {31'd0, f_in_ready}, 32'd1);
    step();
    chk("flow_c1_data", {24'd0, f_out_data}, 32'hC1);
    chk("flow_stall_in_ready", {31'd0, f_in_ready}, 32'd0);
    f_out_ready = 1; f_in_data = 8'hC2;
    #1;
    chk("flow_ready_in_ready", {31'd0, f_in_ready}, 32'd1);
    step();
    chk("flow_c2_data", {24'd0, f_out_data}, 32'hC2);
    chk("flow_c2_occ", {30'd0, f_occ}, 32'd1);
    f_in_valid = 0;
    step();
    chk("flow_empty_valid", {31'd0, f_out_valid}, 32'd0);
    chk("flow_empty_data", {24'd0, f_out_data}, {24'd0, NOP});

    // random traffic against per-DUT scoreboards (both start empty here)
    sq.delete(); fq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_in_valid = 1'($urandom_range(0, 1));
      s_in_data = 8'($urandom_range(0, 255));
      s_out_ready = 1'($urandom_range(0, 1));
      s_flush = ($urandom_range(0, 31) == 0);
      f_in_valid = 1'($urandom_range(0, 1));
      f_in_data = 8'($urandom_range(0, 255));
      f_out_ready = 1'($urandom_range(0, 1));
      f_flush = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_s_valid", {31'd0, s_out_valid}, {31'd0, sq.size() != 0});
      chk("rnd_s_occ", {30'd0, s_occ}, 32'(sq.size()));
      chk("rnd_s_in_ready", {31'd0, s_in_ready}, {31'd0, sq.size() < 2});
      if (sq.size() != 0) chk("rnd_s_data", {24'd0, s_out_data}, {24'd0, sq[0]});
      else chk("rnd_s_bubble", {24'd0, s_out_data}, {24'd0, NOP});
      chk("rnd_f_valid", {31'd0, f_out_valid}, {31'd0, fq.size() != 0});
      chk("rnd_f_occ", {30'd0, f_occ}, 32'(fq.size()));
      chk("rnd_f_in_ready", {31'd0, f_in_ready}, {31'd0, (fq.size() == 0) || f_out_ready});
      if (fq.size() != 0) chk("rnd_f_data", {24'd0, f_out_data}, {24'd0, fq[0]});
      else chk("rnd_f_bubble", {24'd0, f_out_data}, {24'd0, NOP});
      s_inf = s_in_valid & s_in_ready; s_outf = s_out_valid & s_out_ready;
      f_inf = f_in_valid & f_in_ready; f_outf = f_out_valid & f_out_ready;
      step();
      if (s_flush) sq.delete();
      else begin
        if (s_outf && sq.size() != 0) void'(sq.pop_front());
        if (s_inf) sq.push_back(s_in_data);
      end
      if (f_flush) fq.delete();
      else begin
        if (f_outf && fq.size() != 0) void'(fq.pop_front());
        if (f_inf) fq.push_back(f_in_data);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
